// File: rtl/acc_seq_pkg.sv
// Shared types and arithmetic helpers for the dense-layer accumulation sequencer.
// Holds the FSM state encoding, default data widths and the saturating narrow.
package acc_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = DEF_DATA_W + 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Clamp a full-width sum into the signed DATA_W output range; no rounding or shift.
    function automatic logic signed [DEF_DATA_W-1:0] sat_to_data(input logic signed [DEF_ACC_W-1:0] v);
        logic signed [DEF_ACC_W-1:0] hi;
        logic signed [DEF_ACC_W-1:0] lo;
        hi = {{(DEF_ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
        lo = ~hi;
        if (v > hi)
            sat_to_data = {1'b0, {(DEF_DATA_W-1){1'b1}}};
        else if (v < lo)
            sat_to_data = {1'b1, {(DEF_DATA_W-1){1'b0}}};
        else
            sat_to_data = v[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Full-width signed accumulator with synchronous clear; sum_sat is the saturated value
// of (acc + in_data), so the caller can capture a result that includes the current term.
module sat_accumulator
    import acc_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] sum_sat
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    assign sum     = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign sum_sat = sat_to_data(sum);

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (enable)
            acc <= sum;
    end

endmodule

// File: rtl/acc_sequencer.sv
// Sequences N_OUT dot products of N_TERMS signed terms each, presenting one saturated
// result per neuron over valid/ready; in_ready/out_valid are pure registered-state decodes.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_TERMS = 136,
    parameter int N_OUT   = 16,
    parameter int ACC_W   = DATA_W + 8,
    parameter int TIDX_W  = 8,
    parameter int OIDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic [TIDX_W-1:0]        term_idx,
    output logic [OIDX_W-1:0]        out_idx,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    state_t state;
    state_t state_nxt;

    logic beat;
    logic last_beat;
    logic last_out;
    logic acc_clr;
    logic acc_en;
    logic signed [DATA_W-1:0] sum_sat;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (term_idx == TIDX_W'(N_TERMS-1));
    assign last_out  = (out_idx == OIDX_W'(N_OUT-1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            acc_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ACCUM;
                        acc_clr   = 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_en = 1'b1;
                        if (last_beat)
                            state_nxt = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (last_out) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = ACCUM;
                            acc_clr   = 1'b1;
                        end
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters and the result register; out_idx deliberately sticks at N_OUT-1 after a pass.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            term_idx <= '0;
            out_idx  <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        term_idx <= '0;
                        out_idx  <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        term_idx <= last_beat ? '0 : term_idx + TIDX_W'(1);
                        if (last_beat)
                            out_data <= sum_sat;
                    end
                end
                OUTPUT: begin
                    if (out_ready && !last_out)
                        out_idx <= out_idx + OIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    sat_accumulator #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clr),
        .enable  (acc_en),
        .in_data (in_data),
        .sum_sat (sum_sat)
    );

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomised bench for acc_sequencer (N_TERMS=4, N_OUT=2) against a queue-based sum/clamp model.
module tb_acc_sequencer;

    localparam int NT = 4;
    localparam int NO = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy, done;
    logic [7:0]  term_idx;
    logic [3:0]  out_idx;
    logic [15:0] out_data;

    int tests_run = 0;
    int tests_failed = 0;

    logic signed [15:0] prod_q[$];
    logic [15:0]        exp_q[$];
    logic [15:0]        res_q[$];
    int                 ridx_q[$];
    int                 done_cnt, tidx_bad, accept_cyc, done_cyc;
    bit                 timeout;

    acc_sequencer #(.N_TERMS(NT), .N_OUT(NO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .term_idx  (term_idx),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] clamp16(input int s);
        if (s > 32767) return 16'h7fff;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Expected result per complete group of NT products currently queued.
    task automatic build_expected();
        exp_q.delete();
        for (int k = 0; k < prod_q.size() / NT; k++) begin
            int s = 0;
            for (int j = 0; j < NT; j++) s += int'(prod_q[k*NT+j]);
            exp_q.push_back(clamp16(s));
        end
    endtask

    task automatic push(input int v);
        prod_q.push_back(16'(v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then feed queued products and collect results. vpct<0 alternates in_valid.
    // stop_beats>=0 returns right after that many beats have transferred.
    task automatic run_pass(input int vpct, input int rpct, input int stop_beats, input bit poke_start);
        int beats = 0;
        int cyc = 0;
        bit fin = 0;
        res_q.delete(); ridx_q.delete();
        done_cnt = 0; tidx_bad = 0; timeout = 0; accept_cyc = -1; done_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!fin) begin
            if (done) begin done_cnt++; done_cyc = cyc; fin = 1; end
            if (in_ready && (term_idx != 8'(beats % NT))) tidx_bad++;
            in_valid  = !fin && (prod_q.size() > 0) &&
                        ((vpct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < vpct));
            in_data   = (prod_q.size() > 0) ? prod_q[0] : 16'h0;
            out_ready = ($urandom_range(99) < rpct);
            start     = poke_start && !fin && ($urandom_range(3) == 0);
            if (in_valid && in_ready) begin void'(prod_q.pop_front()); beats++; end
            if (out_valid && out_ready) begin
                res_q.push_back(out_data); ridx_q.push_back(int'(out_idx)); accept_cyc = cyc;
            end
            if (stop_beats >= 0 && beats >= stop_beats) fin = 1;
            if (cyc >= 3000) begin timeout = 1; fin = 1; end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = 0; out_ready = 0;
        repeat (3) tick();
        tests_run++;
        if ({in_ready, out_valid, busy, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: actual %b required 0000", {in_ready, out_valid, busy, done});
        end
        tests_run++;
        if ({out_data, term_idx, out_idx} !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: actual data=%h tidx=%0d oidx=%0d required all 0", out_data, term_idx, out_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int p[8] = '{1, 2, 3, 4, 10, -3, 0, 5};
        foreach (p[i]) push(p[i]);
        build_expected();
        run_pass(100, 100, -1, 0);
        tests_run++;
        if (timeout || res_q.size() != 2) begin
            tests_failed++;
            $display("FAIL basic_count: actual %0d results (timeout=%0d) required 2", res_q.size(), timeout);
        end
        for (int k = 0; k < 2 && k < res_q.size(); k++) begin
            tests_run++;
            if (res_q[k] !== exp_q[k] || ridx_q[k] != k) begin
                tests_failed++;
                $display("FAIL basic_result%0d: actual %0d@%0d required %0d@%0d",
                         k, $signed(res_q[k]), ridx_q[k], $signed(exp_q[k]), k);
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != accept_cyc + 1) begin
            tests_failed++;
            $display("FAIL basic_done_timing: actual done at %0d after accept %0d, required accept+1", done_cyc, accept_cyc);
        end
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || out_idx !== 4'(NO-1)) begin
            tests_failed++;
            $display("FAIL basic_after: actual done=%b busy=%b oidx=%0d required 0 0 %0d", done, busy, out_idx, NO-1);
        end
    endtask

    task automatic test_saturation();
        repeat (4) push(16'sh7000);
        repeat (4) push(-28672);
        run_pass(100, 100, -1, 0);
        tests_run++;
        if (res_q.size() != 2 || res_q[0] !== 16'h7fff || res_q[1] !== 16'h8000) begin
            tests_failed++;
            $display("FAIL saturation: actual %h %h (n=%0d) required 7fff 8000",
                     res_q.size() > 0 ? res_q[0] : 16'hx, res_q.size() > 1 ? res_q[1] : 16'hx, res_q.size());
        end
    endtask

    task automatic test_stalls();
        int p[8] = '{7, -2, 9, 100, -50, 3, 3, 1};
        foreach (p[i]) push(p[i]);
        build_expected();
        run_pass(-1, 100, -1, 0);
        tests_run++;
        if (tidx_bad != 0 || timeout) begin
            tests_failed++;
            $display("FAIL stall_term_idx: actual %0d bad cycles (timeout=%0d) required 0", tidx_bad, timeout);
        end
        tests_run++;
        if (res_q.size() != 2 || res_q[0] !== exp_q[0] || res_q[1] !== exp_q[1]) begin
            tests_failed++;
            $display("FAIL stall_results: actual n=%0d required %0d,%0d", res_q.size(), $signed(exp_q[0]), $signed(exp_q[1]));
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int p[8] = '{5, 6, 7, 8, 1, 1, 1, 1};
        foreach (p[i]) push(p[i]);
        run_pass(100, 0, 4, 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 16'd100; out_ready = 1'b0;
            if (out_valid !== 1'b1 || out_data !== 16'd26 || in_ready !== 1'b0 || term_idx !== 8'd0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_output: actual %0d unstable cycles required 0 (valid=1 data=26 in_ready=0)", bad);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_idx !== 4'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: actual oidx=%0d in_ready=%b required 1 1", out_idx, in_ready);
        end
        run_pass(100, 100, -1, 0);
        tests_run++;
        if (res_q.size() != 1 || res_q[0] !== 16'd4 || ridx_q[0] != 1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL hold_second: actual n=%0d done=%0d required one result 4@1 and done", res_q.size(), done_cnt);
        end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        int p[6] = '{1, 2, 3, 4, 9, 9};
        foreach (p[i]) push(p[i]);
        run_pass(100, 100, 6, 0);
        tests_run++;
        if (res_q.size() != 1 || res_q[0] !== 16'd10) begin
            tests_failed++;
            $display("FAIL abort_first: actual n=%0d required one result 10", res_q.size());
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: actual busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            if (done) seen_done++;
            tick();
        end
        tests_run++;
        if (seen_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: actual %0d done cycles required 0", seen_done);
        end
        repeat (8) push(1);
        run_pass(100, 100, -1, 0);
        tests_run++;
        if (res_q.size() != 2 || res_q[0] !== 16'd4 || ridx_q[0] != 0 || res_q[1] !== 16'd4) begin
            tests_failed++;
            $display("FAIL abort_restart: actual n=%0d required 4@0 4@1", res_q.size());
        end
    endtask

    task automatic test_reset_mid_output();
        int p[4] = '{300, -20, 11, 2};
        foreach (p[i]) push(p[i]);
        build_expected();
        run_pass(100, 0, 4, 0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL rst_pre_output: actual valid=%b data=%0d required 1 %0d", out_valid, $signed(out_data), $signed(exp_q[0]));
        end
        rst_n = 1'b0; out_ready = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy, done, out_data, term_idx, out_idx} !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_output: actual valid=%b data=%h busy=%b required all 0", out_valid, out_data, busy);
        end
        rst_n = 1'b1; out_ready = 1'b0;
        prod_q.delete();
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NT*NO; i++) begin
                case ($urandom_range(2))
                    0: push(int'($signed(16'($urandom))));
                    1: push(16'sh7000 + int'($urandom_range(4095)));
                    default: push(-32768 + int'($urandom_range(4095)));
                endcase
            end
            build_expected();
            run_pass(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, r[0]);
            tests_run++;
            if (timeout || res_q.size() != NO || done_cnt != 1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL random%0d_flow: actual n=%0d done=%0d busy=%b timeout=%0d", r, res_q.size(), done_cnt, busy, timeout);
            end
            for (int k = 0; k < NO && k < res_q.size(); k++) begin
                tests_run++;
                if (res_q[k] !== exp_q[k] || ridx_q[k] != k) begin
                    tests_failed++;
                    $display("FAIL random%0d_res%0d: actual %h@%0d required %h@%0d", r, k, res_q[k], ridx_q[k], exp_q[k], k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_stalls();
        test_backpressure();
        test_abort();
        test_reset_mid_output();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
